decompress_engine_scheduler: RTL and testbench
==============================================

// Module: decompress_engine_scheduler
// PURPOSE
//  Dispatch scheduler for the 512->64 decompression group. It picks which decompress engine
//  receives the next value, replacing fixed round-robin with credit-aware round-robin.
//  An engine is skipped while its outstanding-value count is at limit or its input FIFO is
//  almost full. Every grant is also pushed to an order stream, so the output collector
//  reassembles values in arrival order.
// PARAMETERS
//  DECOMPRESS_ENGINES_NO  16  number of engines (N); ENG_W = $clog2(N)
//  VALUE_SIZE_BYTES_NO    2   width in bytes of the value-length field
//  MAX_OUTSTANDING        4   max values in flight per engine (credit limit), >=1
//  ORDER_DEPTH            64  order-FIFO entries (power of two)
// PORTS
//  clk              in   1            clock
//  rst              in   1            reset, asynchronous, active-low
//  req_len          in   8*VSB        byte length of the value to dispatch
//  req_valid        in   1            dispatch request
//  req_ready        out  1            request accepted when valid&ready
//  grant_engine     out  ENG_W        engine selected for the accepted value
//  grant_len        out  8*VSB        req_len forwarded with the grant
//  grant_valid      out  1            grant present
//  grant_ready      in   1            datapath consumed the grant
//  eng_almost_full  in   N            per-engine input-FIFO almost-full
//  eng_done         in   N            per-engine 1-cycle pulse: one value fully drained (out_last)
//  ord_engine       out  ENG_W        engine index of the oldest un-collected value
//  ord_valid        out  1            order FIFO non-empty
//  ord_ready        in   1            collector finished that value; pop
//  err_underflow    out  1            sticky: eng_done seen on an engine with zero credits
// BEHAVIOUR
//  Reset (rst=0, async): req_ready=0, grant_valid=0, grant_engine=0, grant_len=0, ord_valid=0,
//   err_underflow=0. All credit counters=0, rr pointer=N-1 (first pick = engine 0), FIFO empty.
//   Mid-operation reset discards pending grant and order entries.
//  FSM states:
//   IDLE:  req_ready = eligible_any && !ord_full.
//   GRANT: req_ready=0. Stays here while grant_valid && !grant_ready; returns to IDLE on grant_ready.
//  Eligible(e) = credit[e] < MAX_OUTSTANDING && !eng_almost_full[e].
//  Accept in IDLE, in the cycle of req_valid&&req_ready:
//   - pick the first eligible engine, searching from rr_ptr+1 upward with wrap at N-1 -> 0
//   - next cycle: grant_valid=1, grant_engine=pick, grant_len=req_len; rr_ptr <= pick
//   - credit[pick]++ and push pick into the order FIFO in the same edge
//   - latency req accept -> grant_valid = 1 cycle; max 1 grant per 2 cycles
//  grant_engine and grant_len are held stable while grant_valid && !grant_ready.
//  Credit decrement: eng_done[e] gives credit[e]--.
//   - Increment and decrement on the same engine in one cycle: net unchanged.
//   - Multiple eng_done bits in one cycle: all are applied.
//   - eng_done on an engine with credit 0: ignored, err_underflow <= 1 (cleared only by reset).
//  Credit counters are $clog2(MAX_OUTSTANDING+1) bits and never exceed MAX_OUTSTANDING.
//  Order FIFO: push on accept, pop on ord_valid&&ord_ready.
//   - Push and pop in the same cycle are both honoured, also when full.
//   - Full blocks req_ready. Pop on empty is ignored.
//   - ord_engine comes from registered read data; it is valid in the same cycle as ord_valid.
//  Zero-length values (req_len=0) are scheduled like any other value and consume one credit.
//  No eligible engine: req_ready=0 and rr_ptr is unchanged.
// CONFIGURATION
//  DECOMP_SCHED_STATS_EN defined: adds port stat_dispatched (out, N*32). This holds one
//   free-running per-engine grant counter that wraps at 2^32 and is reset to 0.
//   It also adds port stat_stall_cycles (out, 32): cycles with req_valid=1 and req_ready=0.
//  Not defined: neither port exists and no counter logic is built. The scheduling
//   behaviour is identical in both builds.
// STRUCTURE
//  Shared package decompress_pkg holds:
//   - ENG_W and credit-width localparams
//   - sched_state_t enum {IDLE, GRANT}
//   - a function rr_next(ptr, mask), the rotate-and-priority-search pick
//  One sub-module: decomp_sched_order_fifo (ENG_W wide, ORDER_DEPTH deep, registered output).
//  The pick is a combinational function, not a module.
// TESTING
//  1 Reset, then 3 requests, all engines free, eng_done held 0 ->
//    grants to engines 0,1,2, each 1 cycle after accept; ord stream 0,1,2.
//  2 MAX_OUTSTANDING=4, N=2, hold eng_done=0, 9 requests ->
//    8 grants alternating 0,1; 9th stalls with req_ready=0. Pulse eng_done[0] -> 9th goes to engine 0.
//  3 eng_almost_full=16'h0006 with rr_ptr=0 -> next grant is engine 3; the masked engines are skipped.
//  4 Same-cycle accept to engine 5 and eng_done[5] with credit[5]=2 ->
//    credit[5] stays 2; err_underflow stays 0.
//  5 eng_done[7] with credit[7]=0 -> err_underflow=1 and stays 1; credit[7]=0.
//  6 ORDER_DEPTH=4, ord_ready=0, 5 requests -> 4 accepted, then req_ready=0.
//    ord_ready=1 for one cycle -> 5th accepted. Assert rst low mid-grant -> all outputs at reset values.

Source files
------------

// File: rtl/decompress_pkg.sv
// Shared types, widths and the round-robin pick for the decompress scheduler.
// Statistics ports are enabled in the top by defining DECOMP_SCHED_STATS_EN.
package decompress_pkg;

    localparam int DEF_ENGINES = 16;
    localparam int DEF_MAX_OUT = 4;
    localparam int MAX_ENG     = 64;
    localparam int IDX_W       = $clog2(MAX_ENG);

    function automatic int eng_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cred_w(input int m);
        return $clog2(m + 1);
    endfunction

    localparam int ENG_W  = eng_w(DEF_ENGINES);
    localparam int CRED_W = cred_w(DEF_MAX_OUT);

    typedef enum logic {
        IDLE,
        GRANT
    } sched_state_t;

    // First set bit of mask after ptr, wrapping at n-1; top bit flags a hit.
    function automatic logic [IDX_W:0] rr_next(
        input logic [IDX_W-1:0]   ptr,
        input logic [MAX_ENG-1:0] mask,
        input int                 n
    );
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] k;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= MAX_ENG; i++) begin
            k = IDX_W'((int'(ptr) + i) % n);
            if (!found && i <= n && mask[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/decomp_sched_order_fifo.sv
// Grant-order FIFO with a registered head; simultaneous push and pop
// are both honoured, even when full.
module decomp_sched_order_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign valid   = count != '0;
    assign full    = count == FULL_CNT;
    assign pop_ok  = pop && valid;
    assign push_ok = push && (!full || pop_ok);
    assign rd_next = rd_ptr + AW'(pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            if (push_ok && !pop_ok) begin
                count <= count + (AW + 1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (AW + 1)'(1);
            end
            // Bypass when the pushed entry becomes the new head.
            if (push_ok && wr_ptr == rd_next) begin
                dout <= din;
            end else begin
                dout <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/decompress_engine_scheduler.sv
// Credit-aware round-robin dispatch scheduler for the decompress engine group.
// Define DECOMP_SCHED_STATS_EN to add per-engine grant and stall counters.
module decompress_engine_scheduler
    import decompress_pkg::*;
#(
    parameter int DECOMPRESS_ENGINES_NO = DEF_ENGINES,
    parameter int VALUE_SIZE_BYTES_NO   = 2,
    parameter int MAX_OUTSTANDING       = DEF_MAX_OUT,
    parameter int ORDER_DEPTH           = 64,
    localparam int N  = DECOMPRESS_ENGINES_NO,
    localparam int EW = eng_w(DECOMPRESS_ENGINES_NO),
    localparam int LW = 8 * VALUE_SIZE_BYTES_NO
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [LW-1:0] req_len,
    input  logic          req_valid,
    output logic          req_ready,
    output logic [EW-1:0] grant_engine,
    output logic [LW-1:0] grant_len,
    output logic          grant_valid,
    input  logic          grant_ready,
    input  logic [N-1:0]  eng_almost_full,
    input  logic [N-1:0]  eng_done,
    output logic [EW-1:0] ord_engine,
    output logic          ord_valid,
    input  logic          ord_ready,
    output logic          err_underflow
`ifdef DECOMP_SCHED_STATS_EN
    ,
    output logic [N*32-1:0] stat_dispatched,
    output logic [31:0]     stat_stall_cycles
`endif
);

    localparam int CW = cred_w(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);

    sched_state_t  state;
    sched_state_t  state_nxt;
    logic [CW-1:0] credit [N];
    logic [N-1:0]  elig;
    logic [N-1:0]  empty_cred;
    logic [N-1:0]  inc;
    logic [N-1:0]  dec;
    logic [IDX_W:0] search;
    logic          found;
    logic          accept;
    logic          ord_full;
    logic [EW-1:0] pick;
    logic [EW-1:0] rr_ptr;

    always_comb begin
        elig       = '0;
        empty_cred = '0;
        dec        = '0;
        for (int e = 0; e < N; e++) begin
            empty_cred[e] = credit[e] == '0;
            elig[e]       = credit[e] < CMAX && !eng_almost_full[e];
            dec[e]        = eng_done[e] && !empty_cred[e];
        end
    end

    assign search      = rr_next(IDX_W'(rr_ptr), MAX_ENG'(elig), N);
    assign found       = search[IDX_W];
    assign pick        = EW'(search[IDX_W-1:0]);
    assign req_ready   = rst && state == IDLE && found && !ord_full;
    assign accept      = req_valid && req_ready;
    assign grant_valid = state == GRANT;

    always_comb begin
        inc = '0;
        for (int e = 0; e < N; e++) begin
            inc[e] = accept && pick == EW'(e);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = GRANT;
            GRANT:   if (grant_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rr_ptr        <= EW'(N - 1);
            grant_engine  <= '0;
            grant_len     <= '0;
            err_underflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rr_ptr       <= pick;
                grant_engine <= pick;
                grant_len    <= req_len;
            end
            if (|(eng_done & empty_cred)) begin
                err_underflow <= 1'b1;
            end
        end
    end

    // A grant and a drain on the same engine cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < N; e++) begin
                credit[e] <= '0;
            end
        end else begin
            for (int e = 0; e < N; e++) begin
                if (inc[e] && !dec[e]) begin
                    credit[e] <= credit[e] + CW'(1);
                end else if (dec[e] && !inc[e]) begin
                    credit[e] <= credit[e] - CW'(1);
                end
            end
        end
    end

    decomp_sched_order_fifo #(
        .WIDTH (EW),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (pick),
        .pop   (ord_ready),
        .dout  (ord_engine),
        .valid (ord_valid),
        .full  (ord_full)
    );

`ifdef DECOMP_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_dispatched   <= '0;
            stat_stall_cycles <= '0;
        end else begin
            for (int e = 0; e < N; e++) begin
                if (inc[e]) begin
                    stat_dispatched[e*32 +: 32] <= stat_dispatched[e*32 +: 32] + 32'd1;
                end
            end
            if (req_valid && !req_ready) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decompress_engine_scheduler.sv
// Bench for decompress_engine_scheduler: directed scenarios plus random traffic,
// all compared each cycle against a queue-based scheduling model.
module tb_decompress_engine_scheduler;
    import decompress_pkg::*;

    localparam int N     = 16;
    localparam int MAXO  = 4;
    localparam int DEPTH = 64;
    localparam int LW    = 16;

    typedef logic [CRED_W-1:0] cred_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [LW-1:0]    req_len;
    logic             req_valid;
    logic             req_ready;
    logic [ENG_W-1:0] grant_engine;
    logic [LW-1:0]    grant_len;
    logic             grant_valid;
    logic             grant_ready;
    logic [N-1:0]     eng_almost_full;
    logic [N-1:0]     eng_done;
    logic [ENG_W-1:0] ord_engine;
    logic             ord_valid;
    logic             ord_ready;
    logic             err_underflow;
`ifdef DECOMP_SCHED_STATS_EN
    logic [N*32-1:0]  stat_dispatched;
    logic [31:0]      stat_stall_cycles;
`endif

    always #5 clk = ~clk;

    decompress_engine_scheduler #(
        .DECOMPRESS_ENGINES_NO (N),
        .VALUE_SIZE_BYTES_NO   (2),
        .MAX_OUTSTANDING       (MAXO),
        .ORDER_DEPTH           (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_len         (req_len),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .grant_engine    (grant_engine),
        .grant_len       (grant_len),
        .grant_valid     (grant_valid),
        .grant_ready     (grant_ready),
        .eng_almost_full (eng_almost_full),
        .eng_done        (eng_done),
        .ord_engine      (ord_engine),
        .ord_valid       (ord_valid),
        .ord_ready       (ord_ready),
        .err_underflow   (err_underflow)
`ifdef DECOMP_SCHED_STATS_EN
        ,
        .stat_dispatched   (stat_dispatched),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    int checks = 0;
    int passes = 0;

    // Scheduling model: credits per engine, rr pointer, order queue, pending grant.
    cred_t m_cred [N];
    int    m_rr;
    int    m_q[$];
    bit    m_pend;
    int    m_geng;
    int    m_glen;
    bit    m_err;
    int    seen_g[$];
    int    seen_o[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void model_reset();
        for (int e = 0; e < N; e++) m_cred[e] = '0;
        m_rr = N - 1;
        m_q.delete();
        m_pend = 0;
        m_geng = 0;
        m_glen = 0;
        m_err = 0;
    endfunction

    function automatic bit m_elig(input int e);
        return int'(m_cred[e]) < MAXO && !eng_almost_full[e];
    endfunction

    function automatic int m_pick();
        for (int k = 1; k <= N; k++) begin
            if (m_elig((m_rr + k) % N)) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    // Inputs are already driven; compare, advance the model, step one clock.
    task automatic cycle();
        int pk;
        bit rdy;
        bit acc;
        int inc;
        int dec;
        #1;
        if (!rst) model_reset();
        pk  = m_pick();
        rdy = rst && !m_pend && pk >= 0 && m_q.size() < DEPTH;
        chk("req_ready", req_ready, rdy);
        chk("grant_valid", grant_valid, m_pend);
        if (m_pend || !rst) begin
            chk("grant_engine", grant_engine, m_geng);
            chk("grant_len", grant_len, m_glen);
        end
        chk("ord_valid", ord_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("ord_engine", ord_engine, m_q[0]);
        chk("err_underflow", err_underflow, m_err);
        if (rst) begin
            acc = req_valid && rdy;
            if (m_pend && grant_ready) begin
                seen_g.push_back(m_geng);
                m_pend = 0;
            end
            if (ord_ready && m_q.size() != 0) seen_o.push_back(m_q.pop_front());
            for (int e = 0; e < N; e++) begin
                inc = (acc && pk == e) ? 1 : 0;
                dec = eng_done[e] ? 1 : 0;
                if (dec == 1 && m_cred[e] == 0) begin
                    m_err = 1;
                    dec = 0;
                end
                m_cred[e] = cred_t'(int'(m_cred[e]) + inc - dec);
            end
            if (acc) begin
                m_pend = 1;
                m_geng = pk;
                m_glen = int'(req_len);
                m_rr   = pk;
                m_q.push_back(pk);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        run(1);
        rst = 1'b1;
        seen_g.delete();
        seen_o.delete();
    endtask

    function automatic int sg(input int i);
        return (i < seen_g.size()) ? seen_g[i] : -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        req_len = '0;
        req_valid = 1'b0;
        grant_ready = 1'b1;
        eng_almost_full = '0;
        eng_done = '0;
        ord_ready = 1'b0;
        model_reset();
        @(negedge clk);

        // 1: three requests, all engines free
        run(2);
        chk("t1 reset req_ready", req_ready, 0);
        chk("t1 reset grant_len", grant_len, 0);
        rst = 1'b1;
        run(1);
        req_valid = 1'b1;
        req_len = 16'h0010;
        run(6);
        req_valid = 1'b0;
        run(1);
        chk("t1 grant count", seen_g.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("t1 grant%0d", i), sg(i), i);
        ord_ready = 1'b1;
        run(3);
        ord_ready = 1'b0;
        chk("t1 ord count", seen_o.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1 ord%0d", i), (i < seen_o.size()) ? seen_o[i] : -1, i);
        end

        // 2: two usable engines, credit limit reached, then one drain
        do_reset();
        eng_almost_full = 16'hFFFC;
        req_valid = 1'b1;
        req_len = 16'h0000;
        run(24);
        chk("t2 grant count", seen_g.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t2 grant%0d", i), sg(i), i % 2);
        chk("t2 stalled", req_ready, 0);
        eng_done = 16'h0001;
        run(1);
        eng_done = '0;
        run(4);
        chk("t2 ninth count", seen_g.size(), 9);
        chk("t2 ninth engine", sg(8), 0);
        req_valid = 1'b0;
        eng_almost_full = '0;

        // 3: skip almost-full engines 1 and 2 after rr_ptr=0
        do_reset();
        req_valid = 1'b1;
        run(2);
        eng_almost_full = 16'h0006;
        run(2);
        req_valid = 1'b0;
        eng_almost_full = '0;
        chk("t3 grant count", seen_g.size(), 2);
        chk("t3 skip", sg(1), 3);

        // 4: same-cycle grant and drain on engine 5
        do_reset();
        eng_almost_full = ~16'h0020;
        req_valid = 1'b1;
        run(4);
        req_valid = 1'b0;
        run(1);
        req_valid = 1'b1;
        eng_done = 16'h0020;
        run(1);
        eng_done = '0;
        req_valid = 1'b0;
        run(1);
        chk("t4 no underflow", err_underflow, 0);
        req_valid = 1'b1;
        run(10);
        req_valid = 1'b0;
        chk("t4 grant count", seen_g.size(), 5);
        chk("t4 last engine", sg(4), 5);
        eng_almost_full = '0;

        // 5: drain on an engine with no credit
        do_reset();
        eng_done = 16'h0080;
        run(1);
        eng_done = '0;
        run(3);
        chk("t5 underflow set", err_underflow, 1);
        eng_almost_full = ~16'h0080;
        req_valid = 1'b1;
        run(12);
        req_valid = 1'b0;
        eng_almost_full = '0;
        chk("t5 credit still zero", seen_g.size(), 4);
        chk("t5 underflow sticky", err_underflow, 1);

        // 6: order FIFO full blocks, pop frees, then reset mid-grant
        do_reset();
        req_valid = 1'b1;
        run(128);
        chk("t6 filled", seen_g.size(), 64);
        chk("t6 full stall", req_ready, 0);
        eng_done = 16'h0001;
        run(1);
        eng_done = '0;
        run(6);
        chk("t6 fifo blocks", seen_g.size(), 64);
        ord_ready = 1'b1;
        run(1);
        ord_ready = 1'b0;
        run(3);
        chk("t6 after pop", seen_g.size(), 65);
        chk("t6 after pop engine", sg(64), 0);
        eng_done = '1;
        ord_ready = 1'b1;
        run(1);
        eng_done = '0;
        for (int i = 0; i < 10 && !m_pend; i++) cycle();
        chk("t6 grant pending", m_pend, 1);
        grant_ready = 1'b0;
        run(1);
        rst = 1'b0;
        run(1);
        chk("t6 rst grant_valid", grant_valid, 0);
        chk("t6 rst ord_valid", ord_valid, 0);
        chk("t6 rst req_ready", req_ready, 0);
        chk("t6 rst grant_engine", grant_engine, 0);
        rst = 1'b1;
        grant_ready = 1'b1;
        ord_ready = 1'b0;
        req_valid = 1'b0;
        run(1);

        // random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 999) != 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_len = ($urandom_range(0, 7) == 0) ? '0 : LW'($urandom);
            grant_ready = ($urandom_range(0, 2) != 0);
            ord_ready = ($urandom_range(0, 2) != 0);
            for (int e = 0; e < N; e++) begin
                eng_almost_full[e] = ($urandom_range(0, 9) == 0);
                eng_done[e] = (m_cred[e] != 0 && $urandom_range(0, 5) == 0)
                              || ($urandom_range(0, 2999) == 0);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
